// File: rtl/nibble_search_pkg.sv
// Shared types and defaults for the successive-approximation nibble search engine.
package nibble_search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NIBBLE_W    = 4;
    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/nibble_search_engine_if.sv
// Magnitude-compare handshake between the search engine and the external comparator.
interface nibble_search_engine_if #(
    parameter int WIDTH = 4
);
    logic             cmp_req;
    logic [WIDTH-1:0] cmp_a;
    logic             cmp_ack;
    logic             cmp_gt;

    modport master (
        output cmp_req,
        output cmp_a,
        input  cmp_ack,
        input  cmp_gt
    );

    modport slave (
        input  cmp_req,
        input  cmp_a,
        output cmp_ack,
        output cmp_gt
    );
endinterface

// File: rtl/nibble_search_engine.sv
// Recovers a hidden WIDTH-bit value through a greater-than comparator, MSB first,
// with a per-request ack timeout.
module nibble_search_engine
    import nibble_search_pkg::*;
#(
    parameter int WIDTH   = NIBBLE_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    nibble_search_engine_if.master cmp,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  timeout_err
);

    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(WIDTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_s;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [IDX_W-1:0]   bit_idx_s;
    logic [WAIT_W-1:0]  wait_r;
    logic [WAIT_W-1:0]  wait_s;
    logic               terr_r;
    logic               terr_s;
    logic               cmp_req_r;
    logic [WIDTH-1:0]   cmp_a_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   trial_s;

    // Next-state, trial bookkeeping and timeout decision.
    always_comb begin
        state_s   = state_r;
        result_s  = result_r;
        bit_idx_s = bit_idx_r;
        wait_s    = wait_r;
        terr_s    = terr_r;
        trial_s   = result_r | (WIDTH'(1) << bit_idx_r);
        case (state_r)
            IDLE: begin
                if (start) begin
                    result_s  = '0;
                    terr_s    = 1'b0;
                    bit_idx_s = IDX_MAX;
                    wait_s    = '0;
                    state_s   = REQ;
                end else begin
                    state_s   = IDLE;
                end
            end
            REQ: begin
                // An ack on the final wait cycle still completes the trial.
                if (cmp.cmp_ack) begin
                    if (!cmp.cmp_gt) begin
                        result_s = trial_s;
                    end else begin
                        result_s = result_r;
                    end
                    if (bit_idx_r == IDX_W'(0)) begin
                        state_s = DONE;
                    end else begin
                        bit_idx_s = bit_idx_r - IDX_W'(1);
                        wait_s    = '0;
                        state_s   = GAP;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    terr_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                end
            end
            GAP:     state_s = REQ;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            result_r  <= '0;
            bit_idx_r <= IDX_MAX;
            wait_r    <= '0;
            terr_r    <= 1'b0;
            cmp_req_r <= 1'b0;
            cmp_a_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            result_r  <= result_s;
            bit_idx_r <= bit_idx_s;
            wait_r    <= wait_s;
            terr_r    <= terr_s;
            cmp_req_r <= (state_s == REQ);
            busy_r    <= (state_s == REQ) || (state_s == GAP);
            done_r    <= (state_s == DONE);
            if (state_s == REQ) begin
                cmp_a_r <= result_s | (WIDTH'(1) << bit_idx_s);
            end else begin
                cmp_a_r <= cmp_a_r;
            end
        end
    end

    assign cmp.cmp_req = cmp_req_r;
    assign cmp.cmp_a   = cmp_a_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_nibble_search_engine.sv
// Randomized bench for nibble_search_engine against a greater-than responder with
// configurable ack latency.
module tb_nibble_search_engine;

    localparam int W     = 4;
    localparam int TO    = 15;
    localparam int BOUND = 400;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         timeout_err;

    nibble_search_engine_if #(.WIDTH(W)) bus ();

    nibble_search_engine #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cmp         (bus.master),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .timeout_err (timeout_err)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   secret   = 0;
    int   ack_delay = 0;
    bit   ack_en   = 1'b1;
    int   req_cnt  = 0;
    logic noise    = 1'b0;
    int   done_cnt = 0;
    int   unstable_cnt = 0;
    logic prev_req = 1'b0;
    logic [W-1:0] prev_a = '0;
    int   cands[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: ack after ack_delay cycles of continuous request; gt is garbage without ack.
    assign bus.cmp_ack = bus.cmp_req && ack_en && (req_cnt == ack_delay);
    assign bus.cmp_gt  = bus.cmp_ack ? (int'(bus.cmp_a) > secret) : noise;

    always @(posedge clk) begin
        noise <= 1'($urandom);
        if (!bus.cmp_req || bus.cmp_ack) req_cnt <= 0;
        else                              req_cnt <= req_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.cmp_req && bus.cmp_ack) cands.push_back(int'(bus.cmp_a));
        if (done) done_cnt = done_cnt + 1;
        if (prev_req && bus.cmp_req && (bus.cmp_a != prev_a)) unstable_cnt = unstable_cnt + 1;
        prev_req = bus.cmp_req;
        prev_a   = bus.cmp_a;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Candidate for bit b: the secret's bits above b, bit b set, lower bits clear.
    function automatic int exp_cand(input int sec, input int b);
        return ((sec >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    task automatic run_search(input int sec, input int dly, input bit en,
                              output int res, output int terr, output int cyc,
                              output int dones, output int terr_c1);
        int d0;
        secret    = sec;
        ack_delay = dly;
        ack_en    = en;
        cands.delete();
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        terr_c1 = int'(timeout_err);
        cyc = 1;
        while (!done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_seen", 0, 1);
        res  = int'(result);
        terr = int'(timeout_err);
        repeat (3) @(negedge clk);
        dones = done_cnt - d0;
    endtask

    task automatic check_cands(input string tag, input int sec);
        chk({tag, "_ntrial"}, cands.size(), W);
        for (int i = 0; i < W; i++) begin
            if (i < cands.size()) chk({tag, "_cand"}, cands[i], exp_cand(sec, W - 1 - i));
        end
    endtask

    initial begin
        int res, terr, cyc, dones, tc1, dly, d0, n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_req",    int'(bus.cmp_req), 0);
        chk("rst_a",      int'(bus.cmp_a), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_terr",   int'(timeout_err), 0);

        // Zero-wait responder, secret 5.
        run_search(5, 0, 1'b1, res, terr, cyc, dones, tc1);
        chk("s5_result", res, 5);
        chk("s5_terr", terr, 0);
        chk("s5_cycle", cyc, 2 * W);
        chk("s5_dones", dones, 1);
        check_cands("s5", 5);

        // Extremes.
        run_search(15, 0, 1'b1, res, terr, cyc, dones, tc1);
        chk("s15_result", res, 15);
        check_cands("s15", 15);
        run_search(0, 0, 1'b1, res, terr, cyc, dones, tc1);
        chk("s0_result", res, 0);
        check_cands("s0", 0);

        // Every secret with a random ack latency.
        for (int s = 0; s < (1 << W); s++) begin
            dly = $urandom_range(0, 5);
            run_search(s, dly, 1'b1, res, terr, cyc, dones, tc1);
            chk("ex_result", res, s);
            chk("ex_terr", terr, 0);
            chk("ex_cycle", cyc, W * (dly + 1) + W);
            chk("ex_dones", dones, 1);
            check_cands("ex", s);
        end

        // No ack at all: abort after TIMEOUT request cycles.
        run_search(9, 0, 1'b0, res, terr, cyc, dones, tc1);
        chk("to_terr", terr, 1);
        chk("to_result", res, 0);
        chk("to_cycle", cyc, TO + 1);
        chk("to_dones", dones, 1);
        chk("to_trials", cands.size(), 0);
        run_search(6, 0, 1'b1, res, terr, cyc, dones, tc1);
        chk("to_clear_c1", tc1, 0);
        chk("to_clear_terr", terr, 0);
        chk("to_clear_result", res, 6);

        // Ack on the last allowed wait cycle is accepted; one cycle later is a timeout.
        run_search(11, TO - 1, 1'b1, res, terr, cyc, dones, tc1);
        chk("edge_result", res, 11);
        chk("edge_terr", terr, 0);
        chk("edge_cycle", cyc, W * TO + W);
        run_search(11, TO, 1'b1, res, terr, cyc, dones, tc1);
        chk("late_terr", terr, 1);
        chk("late_cycle", cyc, TO + 1);

        // Start pulses while busy and while in DONE are ignored.
        secret = 10; ack_delay = 0; ack_en = 1'b1;
        cands.delete();
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!done && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("ign_result", int'(result), 10);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ign_dones", done_cnt - d0, 1);
        chk("ign_busy", int'(busy), 0);
        chk("ign_trials", cands.size(), W);

        // Reset in the middle of a search.
        secret = 13; ack_delay = 0;
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req",    int'(bus.cmp_req), 0);
        chk("mrst_a",      int'(bus.cmp_a), 0);
        chk("mrst_busy",   int'(busy), 0);
        chk("mrst_done",   int'(done), 0);
        chk("mrst_result", int'(result), 0);
        chk("mrst_terr",   int'(timeout_err), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mrst_dones", done_cnt - d0, 0);
        chk("mrst_idle", int'(busy), 0);

        chk("a_stable", unstable_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
